// File: rtl/gnn_input_loader.sv
// Serial-to-parallel, double-buffered feature/weight loader for the 4-node GNN top.
// Optional GIL_WEIGHT_REUSE_EN adds reload_w to allow 16-word feature-only frames.
module gnn_input_loader #(
    parameter int W = 5
) (
    input  logic                clk,
`ifdef GIL_WEIGHT_REUSE_EN
    input  logic                reload_w,
`endif
    input  logic                rst,
    input  logic                s_valid,
    input  logic signed [W-1:0] s_data,
    output logic                s_ready,
    input  logic [7:0]          done_flags,
    output logic signed [W-1:0] x0_node0, x1_node0, x2_node0, x3_node0,
    output logic signed [W-1:0] x0_node1, x1_node1, x2_node1, x3_node1,
    output logic signed [W-1:0] x0_node2, x1_node2, x2_node2, x3_node2,
    output logic signed [W-1:0] x0_node3, x1_node3, x2_node3, x3_node3,
    output logic signed [W-1:0] w04, w14, w24, w34,
    output logic signed [W-1:0] w05, w15, w25, w35,
    output logic signed [W-1:0] w06, w16, w26, w36,
    output logic signed [W-1:0] w07, w17, w27, w37,
    output logic signed [W-1:0] w48, w58, w68, w78,
    output logic signed [W-1:0] w49, w59, w69, w79,
    output logic                in_ready,
    output logic                busy
);

    localparam int NWORDS = 40;

    typedef enum logic [1:0] {LOAD, FIRE, BUSY} state_t;

    state_t             state;
    logic [5:0]         cnt;
    logic               seen_low;
    logic signed [W-1:0] shadow [NWORDS];
    logic signed [W-1:0] bank   [NWORDS];
    logic [5:0]         cur_last;
    logic               accept;
    logic               is_last;
    logic               done;

`ifdef GIL_WEIGHT_REUSE_EN
    logic [5:0]         last_idx;

    // Frame length is decided by reload_w on the first word and held for the rest of the frame.
    always_comb begin
        cur_last = last_idx;
        if (cnt == 6'd0) begin
            cur_last = reload_w ? 6'd39 : 6'd15;
        end else begin
            cur_last = last_idx;
        end
    end
`else
    assign cur_last = 6'd39;
`endif

    assign is_last = (cnt == cur_last);
    assign done    = (state == BUSY) && seen_low && (done_flags == 8'hFF);
    assign accept  = s_valid && s_ready;

    // Ready is withheld for the last word while the top is still computing.
    always_comb begin
        s_ready = 1'b0;
        if (rst) begin
            s_ready = 1'b0;
        end else begin
            case (state)
                LOAD:    s_ready = 1'b1;
                FIRE:    s_ready = 1'b0;
                BUSY:    s_ready = !is_last;
                default: s_ready = 1'b0;
            endcase
        end
    end

    // Frame assembly, bank hand-off and completion tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            cnt      <= 6'd0;
            seen_low <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
`ifdef GIL_WEIGHT_REUSE_EN
            last_idx <= 6'd39;
`endif
            for (int i = 0; i < NWORDS; i++) begin
                shadow[i] <= '0;
                bank[i]   <= '0;
            end
        end else begin
            in_ready <= 1'b0;
            if (accept) begin
                shadow[cnt] <= s_data;
                cnt         <= is_last ? 6'd0 : cnt + 6'd1;
`ifdef GIL_WEIGHT_REUSE_EN
                if (cnt == 6'd0) begin
                    last_idx <= cur_last;
                end
`endif
            end
            case (state)
                LOAD: begin
                    // The last word bypasses the shadow so the bank is complete in the FIRE cycle.
                    if (accept && is_last) begin
                        state    <= FIRE;
                        in_ready <= 1'b1;
                        for (int i = 0; i < NWORDS; i++) begin
                            bank[i] <= (6'(i) == cnt) ? s_data : shadow[i];
                        end
                    end
                end
                FIRE: begin
                    state    <= BUSY;
                    busy     <= 1'b1;
                    seen_low <= 1'b0;
                end
                BUSY: begin
                    if (done) begin
                        state <= LOAD;
                        busy  <= 1'b0;
                    end else if (done_flags != 8'hFF) begin
                        seen_low <= 1'b1;
                    end
                end
                default: begin
                    state <= LOAD;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign x0_node0 = bank[0];  assign x1_node0 = bank[1];  assign x2_node0 = bank[2];  assign x3_node0 = bank[3];
    assign x0_node1 = bank[4];  assign x1_node1 = bank[5];  assign x2_node1 = bank[6];  assign x3_node1 = bank[7];
    assign x0_node2 = bank[8];  assign x1_node2 = bank[9];  assign x2_node2 = bank[10]; assign x3_node2 = bank[11];
    assign x0_node3 = bank[12]; assign x1_node3 = bank[13]; assign x2_node3 = bank[14]; assign x3_node3 = bank[15];
    assign w04 = bank[16]; assign w14 = bank[17]; assign w24 = bank[18]; assign w34 = bank[19];
    assign w05 = bank[20]; assign w15 = bank[21]; assign w25 = bank[22]; assign w35 = bank[23];
    assign w06 = bank[24]; assign w16 = bank[25]; assign w26 = bank[26]; assign w36 = bank[27];
    assign w07 = bank[28]; assign w17 = bank[29]; assign w27 = bank[30]; assign w37 = bank[31];
    assign w48 = bank[32]; assign w58 = bank[33]; assign w68 = bank[34]; assign w78 = bank[35];
    assign w49 = bank[36]; assign w59 = bank[37]; assign w69 = bank[38]; assign w79 = bank[39];

endmodule

// File: tb/tb_gnn_input_loader.sv
// Directed self-checking bench for gnn_input_loader (default build; weight-reuse test under GIL_WEIGHT_REUSE_EN).
module tb_gnn_input_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [4:0] s_data;
    logic       s_ready;
    logic [7:0] done_flags;
    logic       in_ready;
    logic       busy;
`ifdef GIL_WEIGHT_REUSE_EN
    logic       reload_w;
`endif
    wire  [4:0] ob [40];

    int checks = 0;
    int errors = 0;
    int ir_count = 0;

    always #5 clk = ~clk;

    // Counts in_ready pulses, one per cycle they are high.
    always @(posedge clk) begin
        if (in_ready) ir_count <= ir_count + 1;
    end

    gnn_input_loader #(.W(5)) dut (
        .clk(clk),
`ifdef GIL_WEIGHT_REUSE_EN
        .reload_w(reload_w),
`endif
        .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .done_flags(done_flags),
        .x0_node0(ob[0]),  .x1_node0(ob[1]),  .x2_node0(ob[2]),  .x3_node0(ob[3]),
        .x0_node1(ob[4]),  .x1_node1(ob[5]),  .x2_node1(ob[6]),  .x3_node1(ob[7]),
        .x0_node2(ob[8]),  .x1_node2(ob[9]),  .x2_node2(ob[10]), .x3_node2(ob[11]),
        .x0_node3(ob[12]), .x1_node3(ob[13]), .x2_node3(ob[14]), .x3_node3(ob[15]),
        .w04(ob[16]), .w14(ob[17]), .w24(ob[18]), .w34(ob[19]),
        .w05(ob[20]), .w15(ob[21]), .w25(ob[22]), .w35(ob[23]),
        .w06(ob[24]), .w16(ob[25]), .w26(ob[26]), .w36(ob[27]),
        .w07(ob[28]), .w17(ob[29]), .w27(ob[30]), .w37(ob[31]),
        .w48(ob[32]), .w58(ob[33]), .w68(ob[34]), .w78(ob[35]),
        .w49(ob[36]), .w59(ob[37]), .w69(ob[38]), .w79(ob[39]),
        .in_ready(in_ready), .busy(busy)
    );

    function automatic logic [4:0] wv(input int v);
        int t;
        t = v;
        return t[4:0];
    endfunction

    // Streams frame indices first..last with value base+idx*step; returns at the negedge after the final accept.
    task automatic stream(input int base, input int step, input int first, input int last, input bit gap);
        bit acc;
        int waited;
        for (int idx = first; idx <= last; idx++) begin
            s_valid = 1'b1;
            s_data  = wv(base + idx * step);
            acc     = 1'b0;
            waited  = 0;
            while (!acc && waited < 100) begin
                #1 acc = s_ready;
                @(negedge clk);
                waited++;
            end
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL accept_timeout: word %0d not accepted, required accept within 100 cycles", idx);
                s_valid = 1'b0;
                return;
            end
            s_valid = 1'b0;
            if (gap && idx < last) @(negedge clk);
        end
    endtask

    task automatic release_done();
        @(negedge clk);
        done_flags = 8'h7F;
        @(negedge clk);
        done_flags = 8'hFF;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; s_valid = 1'b0; s_data = 5'd0; done_flags = 8'hFF;
        @(negedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b, required 0", s_ready); end
        rst = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready: got %b, required 1", s_ready); end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_flags: busy=%b in_ready=%b, required 0 0", busy, in_ready);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) if (ob[i] !== 5'd0) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_bank: %0d nonzero outputs, required 0", bad); end
        @(negedge clk);
    endtask

    task automatic test_full_frame();
        int ir0;
        ir0 = ir_count;
        stream(1, 1, 0, 38, 1'b0);
        checks++;
        if (ir_count !== ir0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL early_in_ready: pulses=%0d in_ready=%b, required %0d 0", ir_count, in_ready, ir0);
        end
        stream(1, 1, 39, 39, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL fire_in_ready: got %b, required 1", in_ready); end
        checks++;
        if (ob[0] !== 5'd1) begin errors++; $display("FAIL x0_node0: got %0d, required 1", ob[0]); end
        checks++;
        if (ob[16] !== 5'b10001) begin errors++; $display("FAIL w04: got %b, required 10001 (-15)", ob[16]); end
        checks++;
        if (ob[39] !== 5'd8) begin errors++; $display("FAIL w79: got %0d, required 8", ob[39]); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || ir_count !== ir0 + 1) begin
            errors++;
            $display("FAIL after_fire: busy=%b in_ready=%b pulses=%0d, required 1 0 %0d", busy, in_ready, ir_count, ir0 + 1);
        end
    endtask

    task automatic test_stale_flags();
        int bad;
        bad = 0;
        done_flags = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1 if (busy !== 1'b1 || s_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stale_flags_busy: %0d bad cycles, required busy=1 s_ready=1 always", bad); end
    endtask

    task automatic test_early_load();
        int bad;
        stream(41, 1, 0, 38, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL early_load_busy: got %b, required 1", busy); end
        s_valid = 1'b1;
        s_data  = wv(41 + 39);
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            #1 if (s_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL last_word_stall: s_ready high %0d times, required 0", bad); end
        done_flags = 8'h7F;
        @(negedge clk);
        done_flags = 8'hFF;
        #1;
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            errors++; $display("FAIL pre_done: busy=%b s_ready=%b, required 1 0", busy, s_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL done_exit: busy=%b s_ready=%b in_ready=%b, required 0 1 0", busy, s_ready, in_ready);
        end
        checks++;
        if (ob[0] !== 5'd1 || ob[39] !== 5'd8) begin
            errors++; $display("FAIL held_bank: x0_node0=%0d w79=%0d, required 1 8", ob[0], ob[39]);
        end
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL second_in_ready: got %b, required 1", in_ready); end
        checks++;
        if (ob[0] !== 5'd9 || ob[39] !== 5'b10000) begin
            errors++; $display("FAIL frame2_bank: x0_node0=%0d w79=%b, required 9 10000", ob[0], ob[39]);
        end
    endtask

    task automatic test_gaps();
        int bad;
        release_done();
        stream(1, 1, 0, 39, 1'b1);
        checks++;
        if (in_ready !== 1'b1 || s_ready !== 1'b0) begin
            errors++; $display("FAIL gap_fire: in_ready=%b s_ready=%b, required 1 0", in_ready, s_ready);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) if (ob[i] !== wv(1 + i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL gap_bank: %0d words differ, required 0", bad); end
    endtask

    task automatic test_reset_midframe();
        int ir0;
        int bad;
        release_done();
        stream(5, 1, 0, 19, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ob[0] !== 5'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL midframe_reset: x0_node0=%0d busy=%b, required 0 0", ob[0], busy);
        end
        ir0 = ir_count;
        stream(100, 1, 0, 38, 1'b0);
        checks++;
        if (ir_count !== ir0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL premature_fire: pulses=%0d in_ready=%b, required %0d 0", ir_count, in_ready, ir0);
        end
        stream(100, 1, 39, 39, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL fresh_fire: got %b, required 1", in_ready); end
        bad = 0;
        for (int i = 0; i < 40; i++) if (ob[i] !== wv(100 + i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL fresh_bank: %0d words differ, required 0", bad); end
    endtask

`ifdef GIL_WEIGHT_REUSE_EN
    task automatic test_weight_reuse();
        int bad;
        release_done();
        reload_w = 1'b1;
        stream(1, 1, 0, 39, 1'b0);
        release_done();
        reload_w = 1'b0;
        stream(-3, 0, 0, 15, 1'b0);
        reload_w = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reuse_fire: got %b, required 1", in_ready); end
        bad = 0;
        for (int i = 0; i < 16; i++) if (ob[i] !== 5'b11101) bad++;
        for (int i = 16; i < 40; i++) if (ob[i] !== wv(1 + i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reuse_bank: %0d words differ, required 0", bad); end
    endtask
`endif

    initial begin
`ifdef GIL_WEIGHT_REUSE_EN
        reload_w = 1'b1;
`endif
        test_reset();
        test_full_frame();
        test_stale_flags();
        test_early_load();
        test_gaps();
        test_reset_midframe();
`ifdef GIL_WEIGHT_REUSE_EN
        test_weight_reuse();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gnn_input_loader.md
# gnn_input_loader

Upstream feeder for the 4-node GNN compute top. Accepts a serial stream of signed 5-bit words over a valid/ready handshake and assembles them into a shadow bank of 16 node features and 24 weights. It then copies the bank to the output registers that drive the top's feature and weight inputs, and pulses `in_ready` once per frame. The block is double-buffered: the next frame loads while the top computes, and the final word of the next frame stalls until the top reports all eight output-ready flags.

## Interface
- `W`, 5, word width; must match the top's 5-bit operands.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  W  signed stream word.
- `s_ready`  out  1  loader accepts a word this cycle.
- `done_flags`  in  8  concatenated `out1x_ready` flags of nodes 3..0 from the top.
- `x0_node0`..`x3_node3`  out  W each  16 signed feature registers.
- `w04`..`w37`  out  W each  16 layer-1 weight registers.
- `w48`..`w79`  out  W each  8 layer-2 weight registers.
- `in_ready`  out  1  one-cycle pulse when the output bank is updated.
- `busy`  out  1  a frame has been issued and is not yet complete.
- `reload_w`  in  1  present only with `GIL_WEIGHT_REUSE_EN`.

## Operation
- Frame word order, index 0..39:
  - 0–15: node0 x0..x3, node1 x0..x3, node2, node3.
  - 16–31: w04,w14,w24,w34, w05..w35, w06..w36, w07..w37.
  - 32–39: w48,w58,w68,w78, w49,w59,w69,w79.
- A word is accepted when `s_valid && s_ready`. The accepted word is written to shadow[cnt], and `cnt` increments. `cnt` wraps to 0 after the last word of the frame.
- States:
  - LOAD: `busy`=0, `s_ready`=1.
  - FIRE: one cycle.
  - BUSY: `busy`=1.
- Transitions:
  - LOAD → FIRE when the last word is accepted.
  - FIRE → BUSY always.
  - BUSY → LOAD on the done condition.
- FIRE:
  - The output bank is copied from the shadow bank.
  - `in_ready`=1.
  - `seen_low` is cleared.
  - `s_ready`=0.
- BUSY:
  - `seen_low` is set in any cycle where `done_flags` != 8'hFF.
  - The done condition is `seen_low && done_flags==8'hFF`. Flags left high from the previous frame therefore cannot end BUSY.
- In BUSY, `s_ready`=1 for non-last words, so the next frame may load early. When `cnt` equals the last index, `s_ready`=0 until BUSY exits.
- Done condition and a new word in the same cycle: the word is accepted only if it is not the last word. The last word is accepted in LOAD on the following cycle.
- Output bank values are held stable from FIRE until the next FIRE.
- `s_valid` low mid-frame: the loader simply waits, with no timeout.

## Timing
- Reset, sampled on `clk`:
  - State = LOAD, `cnt`=0, `seen_low`=0.
  - Shadow and output banks = 0.
  - `in_ready`=0, `busy`=0.
  - `s_ready`=0 during the reset cycle and 1 on the first cycle after.
- Reset mid-frame discards partial shadow contents and restarts at index 0.
- Latency:
  - Last word accepted at cycle N → FIRE at N+1: outputs valid and `in_ready`=1.
  - `busy`=1 from N+2.
  - From the done condition at cycle M: `busy`=0 at M+1, and a stalled last word can be accepted at M+1.
- Minimum frame period is 40 accepted words + 1 FIRE cycle. `in_ready` is never high on two consecutive cycles.

## Configuration
- `GIL_WEIGHT_REUSE_EN` defined:
  - The `reload_w` port exists and is sampled on the first accepted word of a frame (`cnt`==0).
  - If `reload_w`=0, the frame is 16 words (features only). The last index is 15, and the weight shadow and output registers keep their previous values.
  - If `reload_w`=1, the frame is the full 40 words.
- `GIL_WEIGHT_REUSE_EN` undefined: no `reload_w` port, and every frame is 40 words.

## Test plan
- **Reset then full frame.** Reset; stream words 1..40 with words wrapped to signed 5-bit, continuous `s_valid`.
  - `in_ready` pulses once, exactly one cycle after the 40th accept.
  - `x0_node0`=1, `w04`=-15, `w79`=8.
  - `busy`=1 from the next cycle.
- **Stale flags.** Hold `done_flags`=8'hFF through FIRE.
  - `busy` stays 1.
  - Then drop to 8'h7F for 1 cycle and raise to 8'hFF → `busy`=0 one cycle later.
- **Early load stall.** During BUSY, send 40 words.
  - Words 0–38 are accepted.
  - `s_ready`=0 with word 39 pending until done.
  - Word 39 is accepted the cycle `busy` falls.
  - The second `in_ready` fires the next cycle, with outputs still showing frame 1 until then.
- **Gaps in valid.** Stream with `s_valid` toggling every other cycle → identical output bank to the continuous case; FIRE occurs one cycle after the last accept.
- **Reset mid-frame.** Assert `rst` after 20 words, then send a fresh 40-word frame → outputs reflect only the fresh frame; no `in_ready` before its 40th word.
- **Weight reuse (`GIL_WEIGHT_REUSE_EN`).** Send a full frame, then `reload_w`=0 with 16 words of -3.
  - Features = -3; weights unchanged.
  - `in_ready` fires one cycle after the 16th word.
